// File: rtl/theia_pixel_sink.sv
// rtl/theia_pixel_sink.sv - Wishbone pixel-write slave queuing THEIA pixels into a FIFO drained to a framebuffer req/ack port.
// Optional retired-pixel counter: define PIXEL_SINK_STATS_EN.
module theia_pixel_sink #(
    parameter int                    WB_WIDTH     = 32,
    parameter int                    FIFO_DEPTH   = 8,
    parameter int                    FB_ADR_WIDTH = 20,
    parameter logic [WB_WIDTH-1:0]   BASE_ADR     = 32'h0100_0000
) (
    input  logic                          CLK_I,
    input  logic                          RST_I,
    input  logic                          CYC_I,
    input  logic                          STB_I,
    input  logic                          WE_I,
    input  logic [WB_WIDTH-1:0]           ADR_I,
    input  logic [WB_WIDTH-1:0]           DAT_I,
    output logic                          ACK_O,
    output logic                          FB_REQ_O,
    output logic [FB_ADR_WIDTH-1:0]       FB_ADR_O,
    output logic [WB_WIDTH-1:0]           FB_DAT_O,
    input  logic                          FB_ACK_I,
    output logic [$clog2(FIFO_DEPTH):0]   oFifoCount,
    output logic                          oBusy,
    output logic [31:0]                   oPixelCount
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      ack_q, ack_d;
    logic                      fb_req_q, fb_req_d;
    logic [FB_ADR_WIDTH-1:0]   fb_adr_q, fb_adr_d;
    logic [WB_WIDTH-1:0]       fb_dat_q, fb_dat_d;

    logic [FB_ADR_WIDTH-1:0]   adr_mem [FIFO_DEPTH];
    logic [WB_WIDTH-1:0]       dat_mem [FIFO_DEPTH];

    logic [WB_WIDTH-1:0]       offset;
    logic                      in_range;
    logic                      hit;
    logic                      push;
    logic                      pop;

    // Explicit lower-bound test so addresses below BASE_ADR never alias into range
    assign offset   = ADR_I - BASE_ADR;
    assign in_range = (ADR_I >= BASE_ADR) && (offset[WB_WIDTH-1:FB_ADR_WIDTH] == '0);
    assign hit      = CYC_I & STB_I & WE_I & in_range;

    // Fullness uses the registered count only; a same-edge pop never frees a slot early
    assign push     = hit & ~ack_q & (count_q != FULL_C);

    always_ff @(posedge CLK_I) begin
        if (push) begin
            adr_mem[wr_ptr_q] <= offset[FB_ADR_WIDTH-1:0];
            dat_mem[wr_ptr_q] <= DAT_I;
        end
    end

    always_comb begin
        state_d  = state_q;
        fb_req_d = fb_req_q;
        fb_adr_d = fb_adr_q;
        fb_dat_d = fb_dat_q;
        rd_ptr_d = rd_ptr_q;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d  = S_REQ;
                    fb_req_d = 1'b1;
                    fb_adr_d = adr_mem[rd_ptr_q];
                    fb_dat_d = dat_mem[rd_ptr_q];
                end
            end
            S_REQ: begin
                if (FB_ACK_I) begin
                    state_d  = S_IDLE;
                    fb_req_d = 1'b0;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    pop      = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The entry under request stays counted until the framebuffer acknowledges it
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ack_d    = push;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ack_q    <= 1'b0;
            fb_req_q <= 1'b0;
            fb_adr_q <= '0;
            fb_dat_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            fb_req_q <= fb_req_d;
            fb_adr_q <= fb_adr_d;
            fb_dat_q <= fb_dat_d;
        end
    end

`ifdef PIXEL_SINK_STATS_EN
    logic [31:0] pix_cnt_q;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            pix_cnt_q <= '0;
        end else if (pop) begin
            pix_cnt_q <= pix_cnt_q + 32'd1;
        end
    end

    assign oPixelCount = pix_cnt_q;
`else
    assign oPixelCount = 32'b0;
`endif

    assign ACK_O      = ack_q;
    assign FB_REQ_O   = fb_req_q;
    assign FB_ADR_O   = fb_adr_q;
    assign FB_DAT_O   = fb_dat_q;
    assign oFifoCount = count_q;
    assign oBusy      = (count_q != '0) | fb_req_q;

endmodule
